// File: rtl/pipe_hazard_tracker.sv
// Tag pipeline for ID/EX, EX/MEM and MEM/WB feeding the forwarding unit, with
// load-use detection, memory-wait freeze and a saturating stall counter.
module pipe_hazard_tracker #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dst,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             flush,
   input  logic             mem_busy,
   output logic             hold_if_id,
   output logic [REG_W-1:0] IdExRs,
   output logic [REG_W-1:0] IdExRt,
   output logic [REG_W-1:0] IdExDst,
   output logic             IdExRegWrite,
   output logic             IdExMemRead,
   output logic [REG_W-1:0] ExMemDst,
   output logic [REG_W-1:0] MemWbDst,
   output logic             ExMemRegWrite,
   output logic             MemWbRegWrite,
   output logic [CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] dst;
      logic             rw;
      logic             mr;
   } idex_t;

   typedef struct packed {
      logic [REG_W-1:0] dst;
      logic             rw;
   } wr_t;

   idex_t            idex_q, idex_d, id_entry;
   wr_t              exmem_q, exmem_d, memwb_q, memwb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use, hold;

   always_comb begin
      id_entry     = '0;
      id_entry.rs  = id_rs;
      id_entry.rt  = id_rt;
      id_entry.dst = id_dst;
      // Writes to $0 are architecturally discarded, so they never act as producers.
      id_entry.rw  = id_valid & id_reg_write & (id_dst != '0);
      id_entry.mr  = id_valid & id_mem_read & (id_dst != '0);

      load_use = id_valid & idex_q.mr & idex_q.rw &
                 ((id_uses_rs & (id_rs == idex_q.dst)) |
                  (id_uses_rt & (id_rt == idex_q.dst)));

      // Gated by reset so the front end is never told to hold while cleared.
      hold = ~reset & (mem_busy | (load_use & ~flush));

      idex_d  = idex_q;
      exmem_d = exmem_q;
      memwb_d = memwb_q;
      if (!mem_busy) begin
         idex_d      = (flush | load_use) ? idex_t'('0) : id_entry;
         exmem_d.dst = idex_q.dst;
         exmem_d.rw  = idex_q.rw;
         memwb_d     = exmem_q;
      end

      cnt_d = cnt_q;
      if (hold && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
         cnt_q   <= '0;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hold_if_id    = hold;
   assign IdExRs        = idex_q.rs;
   assign IdExRt        = idex_q.rt;
   assign IdExDst       = idex_q.dst;
   assign IdExRegWrite  = idex_q.rw;
   assign IdExMemRead   = idex_q.mr;
   assign ExMemDst      = exmem_q.dst;
   assign ExMemRegWrite = exmem_q.rw;
   assign MemWbDst      = memwb_q.dst;
   assign MemWbRegWrite = memwb_q.rw;
   assign stall_count   = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Directed stimulus with hand-computed expectations queued per cycle; a negedge
// monitor pops and compares them against the tracker outputs.
module tb_pipe_hazard_tracker;

   localparam int HOLD = 0, RS = 1, RT = 2, DST = 3, RW = 4, MR = 5;
   localparam int EMD = 6, MWD = 7, EMW = 8, MWW = 9, CNT = 10, SCNT = 11;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
   logic       flush, mem_busy;
   logic [4:0] id_rs, id_rt, id_dst;

   logic        hold_if_id, IdExRegWrite, IdExMemRead, ExMemRegWrite, MemWbRegWrite;
   logic [4:0]  IdExRs, IdExRt, IdExDst, ExMemDst, MemWbDst;
   logic [15:0] stall_count;

   logic        s_hold, s_rw, s_mr, s_emw, s_mww;
   logic [4:0]  s_rs, s_rt, s_dst, s_emd, s_mwd;
   logic [3:0]  s_cnt;

   always #5 clk = ~clk;

   pipe_hazard_tracker #(.REG_W(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .mem_busy(mem_busy), .hold_if_id(hold_if_id), .IdExRs(IdExRs), .IdExRt(IdExRt),
      .IdExDst(IdExDst), .IdExRegWrite(IdExRegWrite), .IdExMemRead(IdExMemRead),
      .ExMemDst(ExMemDst), .MemWbDst(MemWbDst), .ExMemRegWrite(ExMemRegWrite),
      .MemWbRegWrite(MemWbRegWrite), .stall_count(stall_count)
   );

   // Narrow-counter copy sharing the same stimulus, used to reach saturation quickly.
   pipe_hazard_tracker #(.REG_W(5), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .mem_busy(mem_busy), .hold_if_id(s_hold), .IdExRs(s_rs), .IdExRt(s_rt),
      .IdExDst(s_dst), .IdExRegWrite(s_rw), .IdExMemRead(s_mr),
      .ExMemDst(s_emd), .MemWbDst(s_mwd), .ExMemRegWrite(s_emw),
      .MemWbRegWrite(s_mww), .stall_count(s_cnt)
   );

   typedef struct {
      int          cyc;
      string       name;
      int          sel;
      logic [15:0] val;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] act(input int sel);
      case (sel)
         HOLD:    return 16'(hold_if_id);
         RS:      return 16'(IdExRs);
         RT:      return 16'(IdExRt);
         DST:     return 16'(IdExDst);
         RW:      return 16'(IdExRegWrite);
         MR:      return 16'(IdExMemRead);
         EMD:     return 16'(ExMemDst);
         MWD:     return 16'(MemWbDst);
         EMW:     return 16'(ExMemRegWrite);
         MWW:     return 16'(MemWbRegWrite);
         CNT:     return stall_count;
         SCNT:    return 16'(s_cnt);
         default: return 16'hDEAD;
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      logic [15:0] a;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         a = act(e.sel);
         n_chk++;
         if (a !== e.val) begin
            n_fail++;
            $display("FAIL %s (sel %0d): got %0h, expected %0h", e.name, e.sel, a, e.val);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] dst,
                      input logic rw, input logic mr, input logic fl, input logic busy);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_dst = dst; id_reg_write = rw; id_mem_read = mr; flush = fl; mem_busy = busy;
   endtask

   task automatic chk(input string n, input int sel, input logic [15:0] v);
      q.push_back('{cyc: cyc, name: n, sel: sel, val: v});
   endtask

   task automatic nop();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      nop();
      step();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // mem_busy under reset must not hold
      for (int s = 0; s < 12; s++) chk("reset_init", s, 16'h0);

      // Pipeline flow
      step(); reset = 1'b0;
      drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      chk("flow_hold0", HOLD, 0); chk("flow_rw_pre", RW, 0);
      step(); drv(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
      chk("flow_idex1", DST, 1); chk("flow_idex_rw", RW, 1);
      step(); nop();
      chk("flow_idex2", DST, 2); chk("flow_exmem1", EMD, 1);
      step(); nop();
      chk("flow_memwb1", MWD, 1); chk("flow_exmem_rw", EMW, 1);
      chk("flow_memwb_rw", MWW, 1); chk("flow_exmem2", EMD, 2);

      // $0 suppression
      step(); drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(); nop(); chk("zero_idex_rw", RW, 0);
      step(); nop(); chk("zero_exmem_rw", EMW, 0);

      // Load-use
      step(); drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
      chk("zero_memwb_rw", MWW, 0);
      step(); drv(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
      chk("lu_idex_mr", MR, 1); chk("lu_idex_dst", DST, 5);
      chk("lu_hold", HOLD, 1); chk("lu_cnt0", CNT, 0);
      step(); drv(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
      chk("lu_bubble_rw", RW, 0); chk("lu_exmem5", EMD, 5);
      chk("lu_cnt1", CNT, 1); chk("lu_hold_once", HOLD, 0);
      step(); drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
      chk("lu_accept_dst", DST, 6); chk("lu_accept_rs", RS, 5);
      chk("lu_accept_rw", RW, 1); chk("lu_accept_hold", HOLD, 0); chk("lu_cnt_keep", CNT, 1);

      // Flush beats load-use
      step(); drv(1, 0, 7, 0, 1, 8, 1, 0, 1, 0);
      chk("fl_idex_mr", MR, 1); chk("fl_hold0", HOLD, 0);
      step(); drv(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
      chk("fl_bubble_rw", RW, 0); chk("fl_bubble_mr", MR, 0);
      chk("fl_exmem7", EMD, 7); chk("fl_cnt", CNT, 1);

      // mem_busy freeze
      step(); drv(1, 0, 0, 0, 0, 11, 1, 0, 0, 0);
      step(); drv(1, 3, 4, 0, 0, 12, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(); drv(1, 0, 0, 0, 0, 13, 1, 0, 0, 1);
         chk("mb_dst", DST, 12); chk("mb_rs", RS, 3); chk("mb_rt", RT, 4);
         chk("mb_exmem", EMD, 11); chk("mb_memwb", MWD, 10);
         chk("mb_hold", HOLD, 1); chk("mb_cnt", CNT, 16'(1 + i));
      end
      step(); drv(1, 0, 0, 0, 0, 13, 1, 0, 0, 0);
      chk("mb_end_dst", DST, 12); chk("mb_end_exmem", EMD, 11);
      chk("mb_end_memwb", MWD, 10); chk("mb_end_cnt", CNT, 4); chk("mb_end_hold", HOLD, 0);
      step(); drv(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
      chk("mb_resume_dst", DST, 13); chk("mb_resume_exmem", EMD, 12);
      chk("mb_resume_memwb", MWD, 11);

      // flush + load_use + mem_busy together
      step(); drv(1, 9, 0, 1, 0, 14, 1, 0, 1, 1);
      chk("all3_hold", HOLD, 1); chk("all3_dst", DST, 9);
      step(); drv(1, 9, 0, 1, 0, 14, 1, 0, 1, 0);
      chk("all3_frozen_dst", DST, 9); chk("all3_frozen_mr", MR, 1);
      chk("all3_cnt", CNT, 5); chk("all3_flush_hold", HOLD, 0);
      step(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("all3_bubble_rw", RW, 0); chk("all3_exmem9", EMD, 9);
      chk("all3_memwb13", MWD, 13); chk("all3_cnt_keep", CNT, 5); chk("sat_start", SCNT, 5);

      // Saturation on the narrow counter
      for (int k = 1; k <= 14; k++) begin
         step(); drv(1, 0, 0, 0, 0, 4, 1, 0, 0, 1);
         chk("sat_wide", CNT, 16'(5 + k));
         chk("sat_narrow", SCNT, 16'((5 + k > 15) ? 15 : 5 + k));
      end
      chk("pre_reset_exmem", EMD, 9); chk("pre_reset_memwb", MWD, 13);

      // Reset mid-stream with stages loaded and mem_busy high
      step(); reset = 1'b1;
      for (int s = 0; s < 12; s++) chk("reset_mid", s, 16'h0);
      step(); reset = 1'b0;
      drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      chk("rel_dst", DST, 0); chk("rel_cnt", CNT, 0);
      step(); nop();
      chk("rel_first_dst", DST, 3); chk("rel_first_rw", RW, 1); chk("rel_first_cnt", CNT, 0);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL leftover_expectations: got %0d pending, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_tracker.md
# pipe_hazard_tracker

Carries the destination and source tags of in-flight instructions through the ID/EX, EX/MEM and MEM/WB boundaries of the 5-stage pipeline. It produces the IdExRs/IdExRt/ExMemDst/MemWbDst/RegWrite signals that the forwarding unit consumes, so it is the producer side of that interface. It also detects load-use hazards that forwarding cannot cover and requests IF/ID hold plus an ID/EX bubble. It freezes on memory wait and counts stall cycles.

## Interface
Parameters:
- REG_W, 5, register index width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  REG_W  source registers of the ID instruction
- id_uses_rs, id_uses_rt  in  1  instruction actually reads rs/rt
- id_dst  in  REG_W  destination after rd/rt select
- id_reg_write  in  1  instruction writes the register file
- id_mem_read  in  1  instruction is a load
- flush  in  1  kill the ID instruction (taken branch/jump)
- mem_busy  in  1  data memory not ready; freeze the whole pipe
- hold_if_id  out  1  PC and IF/ID must not update this cycle
- IdExRs, IdExRt  out  REG_W  ID/EX source tags
- IdExDst  out  REG_W  ID/EX destination
- IdExRegWrite, IdExMemRead  out  1
- ExMemDst, MemWbDst  out  REG_W
- ExMemRegWrite, MemWbRegWrite  out  1
- stall_count  out  CNT_W  saturating count of hold cycles

## Operation
- Three register stages hold {rs, rt, dst, reg_write, mem_read}: ID/EX, EX/MEM and MEM/WB. EX/MEM and MEM/WB keep only dst and reg_write.
- Entry qualification:
  - ID/EX.reg_write = id_valid & id_reg_write & (id_dst != 0). Writes to $0 never appear as writers.
  - mem_read is qualified the same way with id_mem_read.
- load_use = id_valid & IdExMemRead & IdExRegWrite & ((id_uses_rs & id_rs == IdExDst) | (id_uses_rt & id_rt == IdExDst)).
- Per-edge update priority, highest first:
  - reset: all stages are cleared (bubble = all fields 0).
  - mem_busy: all three stages hold.
  - flush: ID/EX <= bubble; EX/MEM <= ID/EX; MEM/WB <= EX/MEM.
  - load_use: same as flush.
  - Normal: ID/EX <= ID inputs; EX/MEM <= ID/EX; MEM/WB <= EX/MEM.
- hold_if_id = mem_busy | (load_use & ~flush). A flushed instruction is discarded, so it is never held.
- A load-use stall lasts exactly one cycle. The bubble clears IdExMemRead, after which the load sits in EX/MEM and the forwarding unit covers the dependency.
- stall_count increments on every edge where hold_if_id = 1. It saturates at 2^CNT_W-1 and never wraps.

## Timing
- Reset values: every output is 0. hold_if_id is also 0 while reset is asserted. The forwarding unit therefore sees no writers (ForwardA = ForwardB = 00).
- Reset deasserted mid-stall: state is already cleared, and the first edge after release performs a normal update.
- hold_if_id is combinational from the current inputs and ID/EX state, valid within the same cycle, with no added register.
- Tag latency is one edge per stage: an instruction presented in ID at edge n appears on IdEx* after n, ExMem* after n+1 and MemWb* after n+2, when no freeze or bubble intervenes.
- mem_busy asserted for k cycles extends every stage by k cycles and adds k to stage_count. load_use during mem_busy does not bubble until mem_busy drops.
- flush, load_use and mem_busy all asserted: the pipe freezes and hold_if_id = 1. On the first non-busy cycle, flush wins and produces a bubble.
- Outputs change only on clk rising edge or reset assertion.

## Test plan
- Reset: assert reset mid-stream with arbitrary stages loaded. All outputs read 0 and stall_count = 0 immediately, before any clock edge.
- Pipeline flow: issue dst=1, reg_write=1, then dst=2, reg_write=1. Required after the second edge: IdExDst = 2, ExMemDst = 1. After the third edge: MemWbDst = 1 and ExMemRegWrite = 1.
- $0 suppression: issue id_dst = 0, reg_write = 1. IdExRegWrite, then ExMemRegWrite, then MemWbRegWrite all stay 0.
- Load-use:
  - Issue a load with dst=5, then an instruction with rs=5 and uses_rs=1.
  - hold_if_id = 1 for exactly one cycle and ID/EX becomes a bubble (IdExRegWrite = 0).
  - The next edge accepts the instruction; ExMemDst = 5 at that point.
  - stall_count = 1.
- Flush priority: assert load_use and flush together. hold_if_id = 0, ID/EX becomes a bubble, and stall_count does not increment.
- mem_busy freeze and saturation:
  - Hold mem_busy for 3 cycles with all stages loaded. All tags stay unchanged and stall_count advances by 3.
  - Preload the counter to 0xFFFF (CNT_W = 16) and assert mem_busy. stall_count stays at 0xFFFF.
